booth_arbiter: RTL

Shares one 16x16 signed booth multiplier core between N_REQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the core through clear, load and 16 compute cycles, then returns the 32-bit product with the requester ID over a valid/ready response port.
- Sits between the requesting units and the single multiplier instance.

---
 rtl/booth_ctrl_pkg.sv | 22 ++
 rtl/booth_arbiter_if.sv | 30 +++
 rtl/booth_arbiter_rr.sv | 33 +++
 rtl/booth_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/booth_ctrl_pkg.sv
// Shared constants and types for the booth multiplier arbiter.
package booth_ctrl_pkg;

    localparam int OP_W           = 16;  // operand width
    localparam int PROD_W         = 32;  // product width
    localparam int RUN_CYCLES_DEF = 16;  // core compute cycles after load

    // Controller state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CLR  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_CAPT = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // Operand pair held for the core while an operation is in flight
    typedef struct packed {
        logic [OP_W-1:0] m;
        logic [OP_W-1:0] q;
    } operands_t;

endpackage

// File: rtl/booth_arbiter_if.sv
// Request/response bus between the requesting units and the multiplier arbiter.
interface booth_arbiter_if
    import booth_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) ();

    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [OP_W*N_REQ-1:0] req_m;
    logic [OP_W*N_REQ-1:0] req_q;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [PROD_W-1:0]     rsp_p;

    // Requesters and response consumer
    modport master (
        output req_valid, req_m, req_q, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_m, req_q, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p
    );

endinterface

// File: rtl/booth_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts just after the last winner.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  grant_idx_o
);

    logic found;
    int   cand;

    // Scan requesters in rotation order from last_grant+1 and pick the first one asserted
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves a value held (no latch).
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = 0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = (int'(last_grant_i) + off) % N_REQ;
            if (en_i && !found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/booth_arbiter.sv
// Shares one sequential booth multiplier core between N_REQ requesters.
module booth_arbiter
    import booth_ctrl_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int RUN_CYCLES = RUN_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,      // synchronous, active-low
    booth_arbiter_if.slave    bus,
    output logic              mul_reset,
    output logic              mul_load,
    output logic [OP_W-1:0]   mul_m,
    output logic [OP_W-1:0]   mul_q,
    input  logic [PROD_W-1:0] mul_p
);

    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  run_cnt_q, run_cnt_d;
    operands_t         ops_q, ops_d;
    logic [PROD_W-1:0] rsp_p_q, rsp_p_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              arb_en;
    logic              accept;

    // Grants are only offered while idle and out of reset
    assign arb_en = reset && (state_q == ST_IDLE);
    assign accept = |grant;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_arbiter (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .en_i         (arb_en),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    assign bus.req_ready = grant;
    assign bus.rsp_valid = reset && (state_q == ST_DONE);
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_id    = rsp_id_q;

    // Core is held in clear while the arbiter itself is in reset
    assign mul_reset = !reset || (state_q == ST_CLR);
    assign mul_load  = reset && (state_q == ST_LOAD);
    assign mul_m     = ops_q.m;
    assign mul_q     = ops_q.q;

    // Next-state logic: sequence the core through clear, load, compute and capture
    always_comb begin
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        ops_d        = ops_q;
        rsp_p_d      = rsp_p_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ops_d.m      = bus.req_m[grant_idx*OP_W +: OP_W];
                    ops_d.q      = bus.req_q[grant_idx*OP_W +: OP_W];
                    rsp_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                    state_d      = ST_CLR;
                end
            end
            ST_CLR:  state_d = ST_LOAD;
            ST_LOAD: begin
                run_cnt_d = '0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (run_cnt_q == CNT_W'(RUN_CYCLES - 1)) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                rsp_p_d = mul_p;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!reset) begin
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            ops_q        <= '0;
            rsp_p_q      <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            ops_q        <= ops_d;
            rsp_p_q      <= rsp_p_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
